// File: rtl/muldiv_iter.sv
// Iterative RV32M multiply/divide unit.
// One request in flight: IDLE accepts, BUSY iterates 32 times (shift-add
// multiply or restoring divide, one bit per cycle), DONE holds the result
// until the consumer takes it. Divide-by-zero and signed overflow can
// optionally short-circuit straight to DONE.
module muldiv_iter #(
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_in1_i,
  input  logic [31:0] req_in2_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] resp_out_o,
  output logic        busy_o
);

  // funct3 encodings of the M extension
  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_n;
  logic [2:0]  op_q;
  logic        neg_q;     // final result must be negated
  logic [4:0]  cnt_q;     // iteration index 0..31
  logic [31:0] hi_q;      // mul: product high half / div: partial remainder
  logic [31:0] lo_q;      // mul: multiplier shifting out / div: dividend in, quotient out
  logic [31:0] opnd_q;    // mul: multiplicand magnitude / div: divisor magnitude
  logic [31:0] res_q;

  logic accept, step, finish;

  // ---------------------------------------------------------------------
  // Request decode, only meaningful on the accept edge
  // ---------------------------------------------------------------------
  logic        s1_sgn, s2_sgn, s1, s2;
  logic        is_div, is_rem, div_zero, div_ovf, early, neg_in;
  logic [31:0] mag1, mag2, early_res;

  // operand signs, magnitudes, result sign and the early-out shortcut value
  always_comb begin
    s1_sgn   = (req_op_i == OP_MUL) || (req_op_i == OP_MULH) || (req_op_i == OP_MULHSU) ||
               (req_op_i == OP_DIV) || (req_op_i == OP_REM);
    s2_sgn   = (req_op_i == OP_MUL) || (req_op_i == OP_MULH) ||
               (req_op_i == OP_DIV) || (req_op_i == OP_REM);
    s1       = s1_sgn & req_in1_i[31];
    s2       = s2_sgn & req_in2_i[31];
    mag1     = s1 ? (32'd0 - req_in1_i) : req_in1_i;
    mag2     = s2 ? (32'd0 - req_in2_i) : req_in2_i;
    is_div   = req_op_i[2];
    is_rem   = req_op_i[2] & req_op_i[1];
    div_zero = (req_in2_i == 32'd0);
    div_ovf  = ((req_op_i == OP_DIV) || (req_op_i == OP_REM)) &&
               (req_in1_i == 32'h8000_0000) && (req_in2_i == 32'hFFFF_FFFF);
    // A zero divisor yields an all-ones quotient magnitude; forcing the
    // quotient sign off keeps DIV x/0 at 0xFFFFFFFF for negative x too.
    if (is_rem)      neg_in = s1;
    else if (is_div) neg_in = (s1 ^ s2) & ~div_zero;
    else             neg_in = s1 ^ s2;
    early     = EARLY_OUT && is_div && (div_zero || div_ovf);
    if (div_zero)    early_res = is_rem ? req_in1_i : 32'hFFFF_FFFF;
    else             early_res = is_rem ? 32'd0 : 32'h8000_0000;
  end

  // ---------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------
  logic [32:0] mul_sum, div_sh, div_diff;
  logic        div_ge;
  logic [31:0] hi_n, lo_n;

  // shift-add multiply or restoring divide, selected by the latched op
  always_comb begin
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : 33'd0);
    div_sh   = {hi_q, lo_q[31]};
    div_diff = div_sh - {1'b0, opnd_q};
    // partial remainder stays below the divisor (or is a dividend prefix
    // when dividing by zero), so bit 32 of the difference is the borrow
    div_ge   = ~div_diff[32];
    if (op_q[2]) begin
      hi_n = div_ge ? div_diff[31:0] : div_sh[31:0];
      lo_n = {lo_q[30:0], div_ge};
    end else begin
      hi_n = mul_sum[32:1];
      lo_n = {mul_sum[0], lo_q[31:1]};
    end
  end

  // ---------------------------------------------------------------------
  // Final sign fix-up and result selection, taken from the last step
  // ---------------------------------------------------------------------
  logic [63:0] prod;
  logic [31:0] quo, rmd, fin_res;

  // apply result sign and pick the half / quotient / remainder per op
  always_comb begin
    prod = neg_q ? (64'd0 - {hi_n, lo_n}) : {hi_n, lo_n};
    quo  = neg_q ? (32'd0 - lo_n) : lo_n;
    rmd  = neg_q ? (32'd0 - hi_n) : hi_n;
    case (op_q)
      OP_MUL:                       fin_res = prod[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[63:32];
      OP_DIV, OP_DIVU:              fin_res = quo;
      default:                      fin_res = rmd;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  // state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_n;
  end

  // next state, datapath enables and handshake outputs; flush overrides all
  always_comb begin
    state_n      = state_q;
    accept       = 1'b0;
    step         = 1'b0;
    finish       = 1'b0;
    req_ready_o  = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_DONE);
    busy_o       = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          accept  = 1'b1;
          state_n = early ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        step = 1'b1;
        if (cnt_q == 5'd31) begin
          finish  = 1'b1;
          state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready_i) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (flush_i) begin
      state_n = S_IDLE;
      accept  = 1'b0;
      step    = 1'b0;
      finish  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  // latch operands on accept, iterate while busy, capture result at the end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      op_q   <= 3'd0;
      neg_q  <= 1'b0;
      cnt_q  <= 5'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      opnd_q <= 32'd0;
      res_q  <= 32'd0;
    end else if (accept) begin
      op_q   <= req_op_i;
      neg_q  <= neg_in;
      cnt_q  <= 5'd0;
      hi_q   <= 32'd0;
      lo_q   <= is_div ? mag1 : mag2;
      opnd_q <= is_div ? mag2 : mag1;
      if (early) res_q <= early_res;
    end else if (step) begin
      cnt_q <= cnt_q + 5'd1;
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (finish) res_q <= fin_res;
    end
  end

  assign resp_out_o = res_q;

endmodule
